fetch_unit: RTL and testbench

Instruction-fetch stage that sits on the far side of the pipeline controller's IF-side interface. It owns the PC, issues requests to instruction memory, holds the IF/ID register, and reports `pval` and the IF-stage interrupt bit `intp_if` to the controller. It consumes the controller's `ifid_ctr` and `jmp_type` to advance, hold, flush, or redirect fetch.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/fetch_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: controller IF/ID commands, jump types and fetch FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    CTR_ADV   = 2'b00,
    CTR_FLUSH = 2'b01,
    CTR_STALL = 2'b10   // 2'b11 is also treated as a stall
  } ifid_ctr_e;

  typedef enum logic [1:0] {
    JT_SEQ  = 2'b00,
    JT_JMPR = 2'b01,
    JT_JMPI = 2'b10,
    JT_INT  = 2'b11
  } jmp_type_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_FULL  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry holding register for a fetched word that arrived while IF/ID was stalled.
module fetch_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INSN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [INSN_W-1:0] insn_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [INSN_W-1:0] insn_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [INSN_W-1:0] insn_q;
  logic [ADDR_W-1:0] pc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      insn_q  <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      insn_q  <= insn_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign insn_o  = insn_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory, holds IF/ID and
// reacts to the controller's advance/flush/stall and redirect commands.
module fetch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC  = ADDR_W'(32'h100),
  parameter int unsigned       PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_data,
  input  logic [1:0]        ifid_ctr,
  input  logic [1:0]        jmp_type,
  input  logic [ADDR_W-1:0] jmpr_tgt,
  input  logic [ADDR_W-1:0] jmpi_tgt,
  input  logic              ext_int,
  input  logic              int_en,
  output logic              pval,
  output logic [INSN_W-1:0] ifid_insn,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              intp_if,
  output logic [ADDR_W-1:0] epc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;      // address of the outstanding (or next) request
  logic [ADDR_W-1:0] tgt_q, tgt_d;    // redirect target parked while draining
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [INSN_W-1:0] ifid_insn_q, ifid_insn_d;
  logic              pval_q, pval_d;
  logic              intp_q, intp_d;

  logic              req, ack, redirect;
  logic [ADDR_W-1:0] pc_next, redir_pc, oldest_pc;
  logic              buf_load, buf_clear, buf_valid;
  logic [INSN_W-1:0] buf_insn;
  logic [ADDR_W-1:0] buf_pc;

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .insn_i  (imem_data),
    .pc_i    (pc_q),
    .valid_o (buf_valid),
    .insn_o  (buf_insn),
    .pc_o    (buf_pc)
  );

  // Gating with rst keeps the request low while reset is held and drops any stale ack.
  assign req      = !rst && (state_q != ST_FULL);
  assign ack      = imem_ack && req;
  assign redirect = (jmp_type != JT_SEQ);
  assign pc_next  = pc_q + ADDR_W'(PC_INC);

  always_comb begin
    case (jmp_type)
      JT_JMPR: redir_pc = jmpr_tgt;
      JT_JMPI: redir_pc = jmpi_tgt;
      default: redir_pc = INT_VEC;
    endcase
    // Resume point when IF/ID is empty: buffered word, else the parked target, else the live request.
    if (buf_valid)                oldest_pc = buf_pc;
    else if (state_q == ST_DRAIN) oldest_pc = tgt_q;
    else                          oldest_pc = pc_q;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    epc_d       = epc_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_insn_d = ifid_insn_q;
    pval_d      = pval_q;
    intp_d      = intp_q | (ext_int & int_en);
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    if (redirect) begin
      pval_d    = 1'b0;
      buf_clear = 1'b1;
      if (jmp_type == JT_INT) begin
        intp_d = 1'b0;
        epc_d  = pval_q ? ifid_pc_q : oldest_pc;
      end
      case (state_q)
        ST_FETCH: begin
          if (ack) begin
            pc_d = redir_pc;
          end else begin
            state_d = ST_DRAIN;
            tgt_d   = redir_pc;
          end
        end
        ST_FULL: begin
          state_d = ST_FETCH;
          pc_d    = redir_pc;
        end
        default: begin
          if (ack) begin
            state_d = ST_FETCH;
            pc_d    = redir_pc;
          end else begin
            tgt_d = redir_pc;
          end
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ifid_ctr == CTR_ADV) begin
            pval_d = ack;
            if (ack) begin
              ifid_insn_d = imem_data;
              ifid_pc_d   = pc_q;
              pc_d        = pc_next;
            end
          end else begin
            // Flush only kills IF/ID; a word landing now is kept in the buffer either way.
            if (ifid_ctr == CTR_FLUSH) pval_d = 1'b0;
            if (ack) begin
              buf_load = 1'b1;
              state_d  = ST_FULL;
              pc_d     = pc_next;
            end
          end
        end
        ST_FULL: begin
          if (ifid_ctr == CTR_ADV) begin
            ifid_insn_d = buf_insn;
            ifid_pc_d   = buf_pc;
            pval_d      = 1'b1;
            buf_clear   = 1'b1;
            state_d     = ST_FETCH;
          end else if (ifid_ctr == CTR_FLUSH) begin
            pval_d = 1'b0;
          end
        end
        default: begin
          if (ifid_ctr == CTR_ADV || ifid_ctr == CTR_FLUSH) pval_d = 1'b0;
          if (ack) begin
            state_d = ST_FETCH;
            pc_d    = tgt_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      epc_q       <= '0;
      ifid_pc_q   <= '0;
      ifid_insn_q <= '0;
      pval_q      <= 1'b0;
      intp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      epc_q       <= epc_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_insn_q <= ifid_insn_d;
      pval_q      <= pval_d;
      intp_q      <= intp_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign pval      = pval_q;
  assign ifid_insn = ifid_insn_q;
  assign ifid_pc   = ifid_pc_q;
  assign intp_if   = intp_q;
  assign epc       = epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized controller/memory traffic,
// checked against a program-order instruction-stream model.
module tb_fetch_unit;
  import pipe_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] INT_VEC  = 32'h100;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic [1:0]  ifid_ctr, jmp_type;
  logic [31:0] jmpr_tgt, jmpi_tgt;
  logic        ext_int, int_en;
  logic        pval, intp_if;
  logic [31:0] ifid_insn, ifid_pc, epc;

  fetch_unit #(
    .ADDR_W (32), .INSN_W (32), .RESET_PC (RESET_PC), .INT_VEC (INT_VEC), .PC_INC (4)
  ) dut (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack), .imem_data (imem_data),
    .ifid_ctr (ifid_ctr), .jmp_type (jmp_type), .jmpr_tgt (jmpr_tgt), .jmpi_tgt (jmpi_tgt),
    .ext_int (ext_int), .int_en (int_en),
    .pval (pval), .ifid_insn (ifid_insn), .ifid_pc (ifid_pc), .intp_if (intp_if), .epc (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a distinct word per address (odd multiplier is a bijection).
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1;
  endfunction
  always_comb imem_data = insn_of(imem_addr);

  typedef struct packed { logic [31:0] pc; logic [31:0] insn; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  int          n_checks = 0, n_fail = 0, n_pres = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order stream: the next instructions IF/ID must present, in order.
  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, insn: insn_of(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // One controller cycle: drive at negedge, return just after the following posedge.
  // ack_sel: 0 none, 1 force, 2 ack whenever requested, 3 random when requested.
  task automatic cyc(input logic r, input logic [1:0] c, input logic [1:0] j, input int ack_sel);
    @(negedge clk);
    rst = r; ifid_ctr = c; jmp_type = j;
    case (ack_sel)
      0:       imem_ack = 1'b0;
      1:       imem_ack = 1'b1;
      2:       imem_ack = imem_req;
      default: imem_ack = imem_req & 1'($urandom_range(0, 1));
    endcase
    if (r) begin
      exp_q.delete(); gen_pc = RESET_PC;
    end else if (j != JT_SEQ) begin
      exp_q.delete();
      gen_pc = (j == JT_JMPR) ? jmpr_tgt : (j == JT_JMPI) ? jmpi_tgt : INT_VEC;
    end
    top_up();
    @(posedge clk); #1;
  endtask

  // Monitor: pops the stream on every new IF/ID presentation, checks kills, holds and intp_if.
  initial begin
    logic        s_rst, s_int, intp_m, prev_pval;
    logic [1:0]  s_ctr, s_jmp;
    logic [31:0] prev_pc, prev_insn;
    exp_t        e;
    intp_m = 1'b0; prev_pval = 1'b0; prev_pc = '0; prev_insn = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_ctr = ifid_ctr; s_jmp = jmp_type; s_int = ext_int & int_en;
      if (s_rst || s_jmp == JT_INT) intp_m = 1'b0;
      else                          intp_m = intp_m | s_int;
      #1;
      if (mon_en) begin
        check("intp_if", 64'(intp_if), 64'(intp_m));
        if (s_rst || s_jmp != JT_SEQ || s_ctr == CTR_FLUSH) begin
          check("pval_kill", 64'(pval), 64'd0);
        end else if (s_ctr == CTR_ADV) begin
          if (pval) begin
            n_pres++;
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL sb_empty: got pc %0h expected none", ifid_pc);
            end else begin
              e = exp_q.pop_front();
              check("stream_pc", 64'(ifid_pc), 64'(e.pc));
              check("stream_insn", 64'(ifid_insn), 64'(e.insn));
            end
          end
        end else begin
          check("stall_pval", 64'(pval), 64'(prev_pval));
          check("stall_pc", 64'(ifid_pc), 64'(prev_pc));
          check("stall_insn", 64'(ifid_insn), 64'(prev_insn));
        end
      end
      prev_pval = pval; prev_pc = ifid_pc; prev_insn = ifid_insn;
    end
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; ifid_ctr = CTR_ADV; jmp_type = JT_SEQ;
    jmpr_tgt = '0; jmpi_tgt = '0; ext_int = 1'b0; int_en = 1'b0;
    gen_pc = RESET_PC;

    // Reset values
    cyc(1'b1, CTR_ADV, JT_SEQ, 0);
    cyc(1'b1, CTR_ADV, JT_SEQ, 0);
    check("rst_pval", 64'(pval), 64'd0);
    check("rst_insn", 64'(ifid_insn), 64'd0);
    check("rst_ifid_pc", 64'(ifid_pc), 64'd0);
    check("rst_intp", 64'(intp_if), 64'd0);
    check("rst_epc", 64'(epc), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    mon_en = 1;

    // Zero-wait acks: first request right after reset, pval from cycle 2, one word per cycle
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'(RESET_PC));
    @(posedge clk); #1;
    check("c2_pval", 64'(pval), 64'd1);
    check("c2_pc", 64'(ifid_pc), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, CTR_ADV, JT_SEQ, 2);
      check("b2b_pval", 64'(pval), 64'd1);
      check("b2b_pc", 64'(ifid_pc), 64'(4 * k));
    end

    // Stall with an ack: word buffered, request drops, IF/ID holds
    cyc(1'b0, CTR_STALL, JT_SEQ, 1);
    check("stall_req", 64'(imem_req), 64'd0);
    check("stall_ifid", 64'(ifid_pc), 64'd12);
    cyc(1'b0, CTR_STALL, JT_SEQ, 2);
    cyc(1'b0, 2'b11, JT_SEQ, 2);
    check("stall3_req", 64'(imem_req), 64'd0);
    cyc(1'b0, CTR_ADV, JT_SEQ, 0);
    check("release_pc", 64'(ifid_pc), 64'd16);
    check("release_addr", 64'(imem_addr), 64'd20);
    check("release_req", 64'(imem_req), 64'd1);

    // Immediate jump with the response two cycles late: drain, then fetch at the target
    jmpi_tgt = 32'h40;
    cyc(1'b0, CTR_ADV, JT_JMPI, 0);
    check("drain_addr", 64'(imem_addr), 64'd20);
    check("drain_pval", 64'(pval), 64'd0);
    cyc(1'b0, CTR_ADV, JT_SEQ, 0);
    check("drain_pval2", 64'(pval), 64'd0);
    cyc(1'b0, CTR_ADV, JT_SEQ, 1);
    check("drain_done_pval", 64'(pval), 64'd0);
    check("drain_tgt_addr", 64'(imem_addr), 64'h40);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);

    // Register jump coinciding with an ack: no drain
    jmpr_tgt = 32'h1C;
    cyc(1'b0, CTR_ADV, JT_JMPR, 1);
    check("jmpr_addr", 64'(imem_addr), 64'h1C);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    check("at_0x20", 64'(ifid_pc), 64'h20);

    // Interrupt while 0x20 is valid in IF/ID
    ext_int = 1'b1; int_en = 1'b1;
    cyc(1'b0, CTR_STALL, JT_SEQ, 0);
    check("intp_set", 64'(intp_if), 64'd1);
    ext_int = 1'b0;
    cyc(1'b0, CTR_STALL, JT_INT, 1);
    check("int_epc", 64'(epc), 64'h20);
    check("int_addr", 64'(imem_addr), 64'(INT_VEC));
    check("int_clr", 64'(intp_if), 64'd0);

    // Flush keeps fetch going
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    cyc(1'b0, CTR_FLUSH, JT_SEQ, 0);
    check("flush_pval", 64'(pval), 64'd0);
    check("flush_req", 64'(imem_req), 64'd1);
    check("flush_addr", 64'(imem_addr), 64'h104);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    check("after_flush_pc", 64'(ifid_pc), 64'h104);

    // Interrupt with IF/ID empty: resume at the outstanding request
    cyc(1'b0, CTR_FLUSH, JT_SEQ, 0);
    cyc(1'b0, CTR_ADV, JT_INT, 1);
    check("int_epc_empty", 64'(epc), 64'h108);

    // PC wrap-around
    jmpi_tgt = 32'hFFFF_FFFC;
    cyc(1'b0, CTR_ADV, JT_JMPI, 2);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    check("wrap_pc", 64'(ifid_pc), 64'hFFFF_FFFC);
    check("wrap_addr", 64'(imem_addr), 64'd0);

    // Reset in the middle of a drain, stale ack during reset
    jmpr_tgt = 32'h200;
    cyc(1'b0, CTR_ADV, JT_JMPR, 0);
    cyc(1'b1, CTR_ADV, JT_SEQ, 1);
    check("midrst_req", 64'(imem_req), 64'd0);
    cyc(1'b0, CTR_ADV, JT_SEQ, 0);
    check("postrst_req", 64'(imem_req), 64'd1);
    check("postrst_addr", 64'(imem_addr), 64'(RESET_PC));
    check("postrst_pval", 64'(pval), 64'd0);
    cyc(1'b0, CTR_ADV, JT_SEQ, 2);
    check("postrst_fetch", 64'(ifid_pc), 64'(RESET_PC));
    check("postrst_pval1", 64'(pval), 64'd1);

    // Randomized controller and memory traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [1:0] c, j;
      int         p;
      r = ($urandom_range(0, 499) == 0);
      p = int'($urandom_range(0, 9));
      c = (p < 6) ? CTR_ADV : (p == 6) ? CTR_FLUSH : 2'($urandom_range(2, 3));
      j = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : JT_SEQ;
      jmpr_tgt = $urandom & ~32'h3;
      jmpi_tgt = $urandom & ~32'h3;
      cyc(r, c, j, 3);
      ext_int = ($urandom_range(0, 19) == 0);
      int_en  = 1'($urandom_range(0, 1));
    end
    check("liveness", 64'(n_pres > 200), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
